// File: rtl/rgb_pkg.sv
// Shared definitions for the RGBW pixel-word path: word layout, the stream-reset
// word and the arbiter state / source encodings.
package rgb_pkg;

   // Pixel-word layout
   localparam int unsigned bnum_valid        = 31;
   localparam int unsigned bnum_stream_reset = 30;
   localparam int unsigned g_msb             = 23;
   localparam int unsigned g_lsb             = 16;
   localparam int unsigned r_msb             = 15;
   localparam int unsigned r_lsb             = 8;
   localparam int unsigned b_msb             = 7;
   localparam int unsigned b_lsb             = 0;

   localparam logic [31:0] stream_rst_word = 32'hC000_0000;

   // Source encodings as seen on out_active_src
   localparam logic [1:0] src_none = 2'd0;
   localparam logic [1:0] src_a    = 2'd1;
   localparam logic [1:0] src_b    = 2'd2;
   localparam logic [1:0] src_inj  = 2'd3;

   // State values double as the out_active_src encoding
   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StGrantA    = 2'd1,
      StGrantB    = 2'd2,
      StInjectRst = 2'd3
   } arb_state_e;

   // A valid word that carries the stream-reset flag closes a frame
   function automatic logic is_frame_end(input logic [31:0] word);
      return word[bnum_valid] & word[bnum_stream_reset];
   endfunction

endpackage

// File: rtl/rgb_frame_timer.sv
// Idle counter with clear/load and a terminal-count pulse. tc fires on the
// increment that would take the count to LIMIT-1, so the owner can act in the
// same clock; clear and load both take priority over counting.
module rgb_frame_timer #(
   parameter int unsigned LIMIT = 9600,
   parameter int unsigned W     = (LIMIT > 2) ? $clog2(LIMIT) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic         tc
);

   logic [W-1:0] cnt;

   // Counter state; saturates at LIMIT-1 so it never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (inc && (cnt != W'(LIMIT - 1))) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Terminal-count pulse, suppressed by a same-clock clear or load
   always_comb begin
      tc = inc & ~clr & ~load & (cnt == W'(LIMIT - 2));
   end

endmodule

// File: rtl/rgb_frame_arb.sv
// Frame-boundary arbiter between two pixel-word sources feeding one FIFO write
// port. Sources are switched only between frames; a stalled or disabled frame is
// closed with an injected stream-reset word.
module rgb_frame_arb
   import rgb_pkg::*;
#(
   parameter int unsigned FRAME_TIMEOUT = 9600,
   parameter int unsigned INJ_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_enable,
   input  logic [1:0]           in_src_mode,
   input  logic                 in_a_valid,
   input  logic [31:0]          in_a_data,
   output logic                 out_a_ready,
   input  logic                 in_b_valid,
   input  logic [31:0]          in_b_data,
   output logic                 out_b_ready,
   input  logic                 in_wr_fifo_full,
   output logic                 out_wr_fifo_en,
   output logic [31:0]          out_wr_fifo_data,
   output logic [1:0]           out_active_src,
   output logic [INJ_CNT_W-1:0] out_inject_cnt
);

   localparam int unsigned TimerW = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;

   arb_state_e state;
   logic       rr_next;   // 0 = A, 1 = B
   logic       cur_src;   // source of the frame in progress, 0 = A, 1 = B

   logic        granted;
   logic        accept;
   logic [31:0] word;
   logic        timeout;
   logic        idle_go;
   logic        idle_sel;

   // Handshake and FIFO write path, zero latency from the inputs
   always_comb begin
      granted          = (state == StGrantA) || (state == StGrantB);
      out_a_ready      = (state == StGrantA) & in_enable & ~in_wr_fifo_full;
      out_b_ready      = (state == StGrantB) & in_enable & ~in_wr_fifo_full;
      word             = (state == StGrantB) ? in_b_data : in_a_data;
      accept           = (out_a_ready & in_a_valid) | (out_b_ready & in_b_valid);
      out_wr_fifo_en   = 1'b0;
      out_wr_fifo_data = '0;
      if ((state == StInjectRst) && !in_wr_fifo_full) begin
         out_wr_fifo_en   = 1'b1;
         out_wr_fifo_data = stream_rst_word;
      end else if (accept && word[bnum_valid]) begin
         out_wr_fifo_en   = 1'b1;
         out_wr_fifo_data = word;
      end
   end

   // Source selection out of IDLE; mode is only looked at here
   always_comb begin
      idle_go  = 1'b0;
      idle_sel = 1'b0;
      unique case (in_src_mode)
         2'd0: begin
            idle_go  = in_a_valid;
            idle_sel = 1'b0;
         end
         2'd1: begin
            idle_go  = in_b_valid;
            idle_sel = 1'b1;
         end
         default: begin
            if (rr_next ? in_b_valid : in_a_valid) begin
               idle_go  = 1'b1;
               idle_sel = rr_next;
            end else if (rr_next ? in_a_valid : in_b_valid) begin
               idle_go  = 1'b1;
               idle_sel = ~rr_next;
            end
         end
      endcase
   end

   // Idle clocks inside a granted frame; cleared outside GRANT and on any accept
   rgb_frame_timer #(
      .LIMIT (FRAME_TIMEOUT),
      .W     (TimerW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (~granted | accept),
      .load     (1'b0),
      .load_val ({TimerW{1'b0}}),
      .inc      (granted),
      .tc       (timeout)
   );

   // Arbitration FSM with round-robin pointer and injected-reset counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= StIdle;
         rr_next        <= 1'b0;
         cur_src        <= 1'b0;
         out_inject_cnt <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_enable && idle_go) begin
                  cur_src <= idle_sel;
                  state   <= idle_sel ? StGrantB : StGrantA;
               end
            end
            StGrantA, StGrantB: begin
               if (!in_enable) begin
                  state <= StInjectRst;
               end else if (accept && is_frame_end(word)) begin
                  state   <= StIdle;
                  rr_next <= ~cur_src;
               end else if (timeout) begin
                  state <= StInjectRst;
               end
            end
            StInjectRst: begin
               if (!in_wr_fifo_full) begin
                  state   <= StIdle;
                  rr_next <= ~cur_src;
                  if (out_inject_cnt != {INJ_CNT_W{1'b1}}) begin
                     out_inject_cnt <= out_inject_cnt + 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign out_active_src = state;

endmodule

// File: doc/rgb_frame_arb.md
Name: rgb_frame_arb

Overview:
- Scheduler in front of the 32-bit write side of the FIFO that feeds the RGBW serial output block.
- Shares that single FIFO/serial datapath between two pixel-word sources:
  - A: live decoded WS2812b stream.
  - B: local pattern generator.
- Switches sources only at frame boundaries, which are stream-reset words.
- Injects a stream-reset word itself if the granted source stalls mid-frame or the block is disabled, so the LED chain always sees a clean frame end.

Parameters:
- FRAME_TIMEOUT, 9600: idle clocks within a frame before forced stream-reset (100 us at 96 MHz).
- INJ_CNT_W, 8: width of the saturating injected-reset counter.

Ports:
- clk  in  1  system clock, 96 MHz, same clock as the FIFO w_clk.
- rst_n  in  1  reset, asynchronous and active-low.
- in_enable  in  1  1 = arbitrate; 0 = finish frame with a reset word, then hold idle.
- in_src_mode  in  2  0 = A only, 1 = B only, 2/3 = alternate A/B per frame.
- in_a_valid  in  1  source A word available.
- in_a_data  in  32  source A word: bit31 valid, bit30 stream_reset, [23:16] G, [15:8] R, [7:0] B.
- out_a_ready  out  1  source A word consumed this clock.
- in_b_valid  in  1  source B word available.
- in_b_data  in  32  source B word, same format as A.
- out_b_ready  out  1  source B word consumed this clock.
- in_wr_fifo_full  in  1  FIFO write full.
- out_wr_fifo_en  out  1  FIFO write enable.
- out_wr_fifo_data  out  32  FIFO write data.
- out_active_src  out  2  0 = none, 1 = A, 2 = B, 3 = injecting.
- out_inject_cnt  out  INJ_CNT_W  saturating count of injected stream-resets.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; rr_next = A; timeout count = 0; out_inject_cnt = 0.
  - All combinational outputs evaluate to 0.
- States: IDLE, GRANT_A, GRANT_B, INJECT_RST. out_active_src is registered and equals the state encoding.
- IDLE:
  - Transition only when in_enable = 1.
  - mode 0: go to GRANT_A when in_a_valid = 1.
  - mode 1: go to GRANT_B when in_b_valid = 1.
  - mode 2/3: choose rr_next if it is valid, else the other source if valid, else stay.
  - One cycle in IDLE per frame boundary is required; no word is transferred in IDLE.
- GRANT_x handshake, combinational, zero latency:
  - ready_x = (state == GRANT_x) & in_enable & ~in_wr_fifo_full. The ungranted ready is always 0.
  - Accept = ready_x & valid_x.
  - Accepted word with bit31 = 0: consumed, not written (out_wr_fifo_en = 0).
  - Accepted word with bit31 = 1: out_wr_fifo_en = 1 and out_wr_fifo_data = word, same clock.
  - Accepted word with bit31 = 1 and bit30 = 1: frame end. Next state IDLE; rr_next = other source.
- Timeout:
  - Counter cleared on entry to GRANT_x and on every accept; it increments each GRANT clock without an accept.
  - When the counter reaches FRAME_TIMEOUT-1, go to INJECT_RST. The ready output is 0 from that clock on.
- Disable in GRANT_x (in_enable = 0): next state INJECT_RST. Readies drop in the same clock because ready is gated by in_enable.
- INJECT_RST:
  - out_wr_fifo_data = 32'hC000_0000; out_wr_fifo_en = ~in_wr_fifo_full.
  - On write: out_inject_cnt += 1, saturating at all-ones; rr_next = other source; next state IDLE.
  - While the FIFO is full: hold the state and do not increment.
- out_wr_fifo_data = 0 whenever out_wr_fifo_en = 0.
- A word is never written while in_wr_fifo_full = 1.
- A source change mid-frame is ignored until IDLE. in_src_mode is sampled only in IDLE.
- Simultaneous accept and timeout: the accept wins and the counter clears.
- Reset mid-frame: no reset word is emitted. The downstream serial block handles its own reset.

Decomposition:
- Shared package rgb_pkg:
  - Bit-number constants bnum_valid = 31 and bnum_stream_reset = 30.
  - Colour field bounds.
  - Stream-reset word constant 32'hC000_0000.
  - Source-encoding constants.
- Natural sub-module: rgb_frame_timer, a loadable/clearable idle counter with a terminal-count pulse, reused later by the serial input detector.

Test Plan:
- Mode 0, A sends 0x8000_00FF, 0x8012_3456, 0xC000_0000, FIFO never full -> three FIFO writes in consecutive clocks with identical data; state returns to IDLE; out_active_src 1 -> 0.
- Mode 2, both sources continuously valid, each frame 2 pixels + reset -> FIFO frames alternate A, B, A; never two words from different sources within one frame.
- A word 0x0000_1234 (bit31 = 0) mid-frame -> out_a_ready = 1, no FIFO write, timeout counter cleared.
- FRAME_TIMEOUT = 16, A stalls after 1 pixel -> exactly 16 clocks later 0xC000_0000 written, out_inject_cnt = 1, next frame granted to B in mode 2.
- in_wr_fifo_full held high 5 clocks during GRANT_A and during INJECT_RST -> no writes, no readies, no timeout-driven loss; write occurs the first clock full drops.
- in_enable falls mid-frame -> next clock INJECT_RST, single 0xC000_0000 write, then IDLE with no grants until in_enable returns; async rst_n pulse mid-GRANT zeroes all outputs immediately.
